// File: rtl/mem_stage_sequencer.sv
// mem_stage_sequencer
//   Sequences one memory-stage operation at a time. A read takes RD_ISSUE,
//   then RD_CAPTURE, then DONE. A write takes WR, then DONE. A new Start is
//   accepted in IDLE or DONE, so operations can run back to back.
// Ports:
//   CLK, Reset            rising-edge clock, synchronous active-high reset
//   Start, MemOp[2:0]     request strobe and operation code (latched on accept)
//   Hold                  freezes a busy sequence and masks write/load enables
//   Busy, Done, Overrun   status: busy states, one-cycle done, sticky overrun
//   MemDst1/MemDst2/MemData  address and write-data selects
//   MemRead1/2, MemWrite1/2  port enables (port 1 is never written)
//   IRWrite, ValAWrite, ValBWrite  register load enables
module mem_stage_sequencer (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Start,
  input  logic [2:0] MemOp,
  input  logic       Hold,
  output logic       Busy,
  output logic       Done,
  output logic       Overrun,
  output logic [1:0] MemDst1,
  output logic [1:0] MemDst2,
  output logic [1:0] MemData,
  output logic       MemRead1,
  output logic       MemRead2,
  output logic       MemWrite1,
  output logic       MemWrite2,
  output logic       IRWrite,
  output logic       ValAWrite,
  output logic       ValBWrite
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR,
    DONE
  } state_t;

  state_t     state;
  state_t     stateNext;
  logic [2:0] op;
  logic       canAccept;

  // Decoded fields of the latched op
  logic [1:0] decDst1;
  logic [1:0] decDst2;
  logic [1:0] decData;
  logic       decRead1;
  logic       decRead2;
  logic       decIR;
  logic       decValA;
  logic       decValB;

  function automatic logic isReadOp(input logic [2:0] o);
    return (o == 3'd0) || (o == 3'd1) || (o == 3'd5);
  endfunction

  assign canAccept = (state == IDLE) || (state == DONE);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= IDLE;
      op      <= '0;
      Overrun <= 1'b0;
    end else begin
      state <= stateNext;
      if (canAccept && Start) begin
        op <= MemOp;
      end
      if (!canAccept && Start) begin
        Overrun <= 1'b1;
      end
    end
  end

  // The op is latched on the accept edge, so the branch decision must look
  // at the incoming MemOp rather than the op register.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE: begin
        if (Start) begin
          stateNext = isReadOp(MemOp) ? RD_ISSUE : WR;
        end else begin
          stateNext = IDLE;
        end
      end
      RD_ISSUE:   if (!Hold) stateNext = RD_CAPTURE;
      RD_CAPTURE: if (!Hold) stateNext = DONE;
      WR:         if (!Hold) stateNext = DONE;
      default:    stateNext = IDLE;
    endcase
  end

  always_comb begin
    decDst1  = '0;
    decDst2  = '0;
    decData  = '0;
    decRead1 = 1'b0;
    decRead2 = 1'b0;
    decIR    = 1'b0;
    decValA  = 1'b0;
    decValB  = 1'b0;
    case (op)
      3'd0: begin
        decRead1 = 1'b1;
        decRead2 = 1'b1;
        decIR    = 1'b1;
        decValA  = 1'b1;
      end
      3'd1: begin
        decDst1  = 2'd1;
        decRead1 = 1'b1;
        decValB  = 1'b1;
      end
      3'd5: begin
        decDst1  = 2'd2;
        decRead1 = 1'b1;
        decValB  = 1'b1;
      end
      3'd2: decData = 2'd1;
      3'd3: decDst2 = 2'd1;
      3'd4: begin
        decDst2 = 2'd2;
        decData = 2'd3;
      end
      3'd6: begin
        decDst2 = 2'd1;
        decData = 2'd1;
      end
      3'd7: decData = 2'd2;
      default: ;
    endcase
  end

  // Hold keeps selects and read enables steady but suppresses any write or
  // register load, so a frozen cycle has no side effects.
  always_comb begin
    Busy      = 1'b0;
    Done      = 1'b0;
    MemDst1   = '0;
    MemDst2   = '0;
    MemData   = '0;
    MemRead1  = 1'b0;
    MemRead2  = 1'b0;
    MemWrite1 = 1'b0;
    MemWrite2 = 1'b0;
    IRWrite   = 1'b0;
    ValAWrite = 1'b0;
    ValBWrite = 1'b0;
    case (state)
      RD_ISSUE, RD_CAPTURE: begin
        Busy     = 1'b1;
        MemDst1  = decDst1;
        MemDst2  = decDst2;
        MemData  = decData;
        MemRead1 = decRead1;
        MemRead2 = decRead2;
        if (state == RD_CAPTURE && !Hold) begin
          IRWrite   = decIR;
          ValAWrite = decValA;
          ValBWrite = decValB;
        end
      end
      WR: begin
        Busy      = 1'b1;
        MemDst2   = decDst2;
        MemData   = decData;
        MemWrite2 = !Hold;
      end
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_sequencer.sv
module tb_mem_stage_sequencer;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       Start;
  logic [2:0] MemOp;
  logic       Hold;
  logic       Busy, Done, Overrun;
  logic [1:0] MemDst1, MemDst2, MemData;
  logic       MemRead1, MemRead2, MemWrite1, MemWrite2;
  logic       IRWrite, ValAWrite, ValBWrite;

  mem_stage_sequencer dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .MemOp(MemOp), .Hold(Hold),
    .Busy(Busy), .Done(Done), .Overrun(Overrun),
    .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData),
    .MemRead1(MemRead1), .MemRead2(MemRead2),
    .MemWrite1(MemWrite1), .MemWrite2(MemWrite2),
    .IRWrite(IRWrite), .ValAWrite(ValAWrite), .ValBWrite(ValBWrite)
  );

  always #5 CLK = ~CLK;

  // Per-op table: inputs (op) and the outputs expected while the op is active
  typedef struct packed {
    logic [2:0] op;
    logic       isRead;
    logic [1:0] d1, d2, dat;
    logic       r1, r2, wr2, ir, va, vb;
  } row_t;

  typedef struct packed {
    logic       busy, done;
    logic [1:0] d1, d2, dat;
    logic       r1, r2, wr2, ir, va, vb;
  } phase_t;

  row_t        tbl [8];
  phase_t      q [$];
  logic        ovrM;
  int unsigned nCmp = 0;
  int unsigned nBad = 0;
  int unsigned doneSeen = 0;
  int unsigned wr2Seen = 0;
  int unsigned w1Seen = 0;

  // Vector layout: Busy Done Dst1 Dst2 Data Rd1 Rd2 Wr1 Wr2 IR ValA ValB
  function automatic logic [14:0] mkVec(logic busy, logic done, logic [1:0] d1,
      logic [1:0] d2, logic [1:0] dat, logic r1, logic r2, logic w2,
      logic ir, logic va, logic vb);
    return {busy, done, d1, d2, dat, r1, r2, 1'b0, w2, ir, va, vb};
  endfunction

  function automatic logic [14:0] dutVec();
    return {Busy, Done, MemDst1, MemDst2, MemData, MemRead1, MemRead2,
            MemWrite1, MemWrite2, IRWrite, ValAWrite, ValBWrite};
  endfunction

  function automatic logic [14:0] modelVec(logic h);
    phase_t p;
    if (q.size() == 0) return '0;
    p = q[0];
    return mkVec(p.busy, p.done, p.d1, p.d2, p.dat, p.r1, p.r2,
                 p.wr2 & ~h, p.ir & ~h, p.va & ~h, p.vb & ~h);
  endfunction

  // Accepting an op queues the list of cycles it will spend, one entry each
  function automatic void modelStep(logic s, logic [2:0] o, logic h, logic r);
    phase_t p;
    row_t   w;
    if (r) begin
      q.delete();
      ovrM = 1'b0;
    end else if (q.size() == 0 || q[0].done) begin
      q.delete();
      if (s) begin
        w = tbl[o];
        p = '0;
        p.busy = 1'b1;
        p.d1 = w.d1; p.d2 = w.d2; p.dat = w.dat;
        if (w.isRead) begin
          p.r1 = w.r1; p.r2 = w.r2;
          q.push_back(p);
          p.ir = w.ir; p.va = w.va; p.vb = w.vb;
          q.push_back(p);
        end else begin
          p.d1 = '0;
          p.wr2 = w.wr2;
          q.push_back(p);
        end
        p = '0;
        p.done = 1'b1;
        q.push_back(p);
      end
    end else begin
      if (s) ovrM = 1'b1;
      if (!h) void'(q.pop_front());
    end
  endfunction

  task automatic cmp(input string nm, input logic [15:0] got, input logic [15:0] want);
    nCmp++;
    if (got !== want) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Drive one cycle's inputs, check against model (and an explicit value if
  // useW), then advance across the rising edge.
  task automatic tick(input logic s, input logic [2:0] o, input logic h,
                      input logic r, input string nm, input logic useW,
                      input logic [14:0] w);
    logic [14:0] got;
    Start = s; MemOp = o; Hold = h; Reset = r;
    #1;
    got = dutVec();
    if (Done) doneSeen++;
    if (MemWrite2) wr2Seen++;
    if (MemWrite1) w1Seen++;
    cmp({nm, "/model"}, {Overrun, got}, {ovrM, modelVec(h)});
    if (useW) cmp(nm, {1'b0, got}, {1'b0, w});
    @(posedge CLK);
    modelStep(s, o, h, r);
    @(negedge CLK);
  endtask

  localparam logic [14:0] DONEV = 15'b010_0000_0000_0000;

  initial begin
    int unsigned d0;
    row_t row;

    tbl[0] = '{op:3'd0, isRead:1, d1:0, d2:0, dat:0, r1:1, r2:1, wr2:0, ir:1, va:1, vb:0};
    tbl[1] = '{op:3'd1, isRead:1, d1:1, d2:0, dat:0, r1:1, r2:0, wr2:0, ir:0, va:0, vb:1};
    tbl[2] = '{op:3'd2, isRead:0, d1:0, d2:0, dat:1, r1:0, r2:0, wr2:1, ir:0, va:0, vb:0};
    tbl[3] = '{op:3'd3, isRead:0, d1:0, d2:1, dat:0, r1:0, r2:0, wr2:1, ir:0, va:0, vb:0};
    tbl[4] = '{op:3'd4, isRead:0, d1:0, d2:2, dat:3, r1:0, r2:0, wr2:1, ir:0, va:0, vb:0};
    tbl[5] = '{op:3'd5, isRead:1, d1:2, d2:0, dat:0, r1:1, r2:0, wr2:0, ir:0, va:0, vb:1};
    tbl[6] = '{op:3'd6, isRead:0, d1:0, d2:1, dat:1, r1:0, r2:0, wr2:1, ir:0, va:0, vb:0};
    tbl[7] = '{op:3'd7, isRead:0, d1:0, d2:0, dat:2, r1:0, r2:0, wr2:1, ir:0, va:0, vb:0};

    ovrM = 1'b0;
    Reset = 1'b1; Start = 1'b0; MemOp = '0; Hold = 1'b0;
    @(posedge CLK);
    @(negedge CLK);

    // Reset state
    tick(0, 3'd0, 0, 0, "reset_state", 1, '0);

    // FETCH
    tick(1, 3'd0, 0, 0, "fetch_start", 1, '0);
    tick(0, 3'd7, 0, 0, "fetch_issue", 1, mkVec(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    tick(0, 3'd7, 0, 0, "fetch_capture", 1, mkVec(1, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0));
    tick(0, 3'd0, 0, 0, "fetch_done", 1, DONEV);

    // Sweep all ops; MemOp is scrambled after acceptance
    for (int i = 0; i < 8; i++) begin
      row = tbl[i];
      tick(1, row.op, 0, 0, "sweep_start", 0, '0);
      if (row.isRead) begin
        tick(0, ~row.op, 0, 0, "sweep_issue", 1,
             mkVec(1, 0, row.d1, row.d2, row.dat, row.r1, row.r2, 0, 0, 0, 0));
        tick(0, ~row.op, 0, 0, "sweep_capture", 1,
             mkVec(1, 0, row.d1, row.d2, row.dat, row.r1, row.r2, 0, row.ir, row.va, row.vb));
      end else begin
        tick(0, ~row.op, 0, 0, "sweep_wr", 1,
             mkVec(1, 0, row.d1, row.d2, row.dat, 0, 0, row.wr2, 0, 0, 0));
      end
      tick(0, 3'd0, 0, 0, "sweep_done", 1, DONEV);
    end
    tick(0, 3'd0, 0, 0, "sweep_idle", 1, '0);

    // Back-to-back POP_B then STORE_IND
    d0 = doneSeen;
    tick(1, 3'd1, 0, 0, "b2b_start", 0, '0);
    tick(0, 3'd0, 0, 0, "b2b_issue", 1, mkVec(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    tick(0, 3'd0, 0, 0, "b2b_capture", 1, mkVec(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1));
    tick(1, 3'd4, 0, 0, "b2b_done1", 1, DONEV);
    tick(0, 3'd0, 0, 0, "b2b_wr", 1, mkVec(1, 0, 0, 2, 3, 0, 0, 1, 0, 0, 0));
    tick(0, 3'd0, 0, 0, "b2b_done2", 1, DONEV);
    tick(0, 3'd0, 0, 0, "b2b_idle", 1, '0);
    cmp("b2b_done_count", 16'(doneSeen - d0), 16'd2);

    // Hold during WR of CALL_PC
    d0 = wr2Seen;
    tick(1, 3'd3, 0, 0, "hold_start", 0, '0);
    for (int i = 0; i < 4; i++)
      tick(0, 3'd0, 1, 0, "hold_wr_frozen", 1, mkVec(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tick(0, 3'd0, 0, 0, "hold_wr_release", 1, mkVec(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    tick(0, 3'd0, 0, 0, "hold_done", 1, DONEV);
    cmp("hold_wr2_count", 16'(wr2Seen - d0), 16'd1);

    // Hold does not block Start in IDLE
    tick(1, 3'd6, 1, 0, "hold_idle_start", 0, '0);
    tick(0, 3'd0, 0, 0, "hold_idle_wr", 1, mkVec(1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
    tick(0, 3'd0, 0, 0, "hold_idle_done", 1, DONEV);

    // Overrun during RD_ISSUE of LOAD_IND
    tick(1, 3'd5, 0, 0, "ovr_start", 0, '0);
    tick(1, 3'd2, 0, 0, "ovr_issue", 1, mkVec(1, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0));
    cmp("overrun_set", {15'd0, Overrun}, 16'd1);
    tick(0, 3'd0, 0, 0, "ovr_capture", 1, mkVec(1, 0, 2, 0, 0, 1, 0, 0, 0, 0, 1));
    tick(0, 3'd0, 0, 0, "ovr_done", 1, DONEV);
    tick(0, 3'd0, 0, 0, "ovr_no_second_op", 1, '0);

    // Reset during RD_CAPTURE
    tick(1, 3'd0, 0, 0, "rst_start", 0, '0);
    tick(0, 3'd0, 0, 0, "rst_issue", 0, '0);
    d0 = doneSeen;
    tick(0, 3'd0, 0, 1, "rst_in_capture", 0, '0);
    tick(0, 3'd0, 0, 0, "rst_after", 1, '0);
    cmp("rst_overrun_cleared", {15'd0, Overrun}, 16'd0);
    tick(0, 3'd0, 0, 0, "rst_after2", 1, '0);
    cmp("rst_no_done", 16'(doneSeen - d0), 16'd0);

    // Start together with Reset is Reset only
    tick(1, 3'd3, 0, 1, "start_rst", 0, '0);
    tick(0, 3'd0, 0, 0, "start_rst_idle", 1, '0);

    // Randomized traffic checked against the model
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 99) < 35), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 3),
           "random", 0, '0);
    end

    cmp("memwrite1_never", 16'(w1Seen), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
